// File: rtl/cg_pkg.sv
// rtl/cg_pkg.sv - shared types and constants for the clock-gated sequencing controller
package cg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CALC,
      ST_OUT,
      ST_CLR
   } cg_state_t;

   localparam int N_IN_DEF        = 6;
   localparam int CALC_CYCLES_DEF = 3;
   localparam int OUT_LEN_DEF     = 6;
   localparam int MODE_W          = 3;
   localparam int DATA_W          = 9;

endpackage

// File: rtl/cg_sleep_dec.sv
// rtl/cg_sleep_dec.sv - sleep decode for the gated clock cells of each register group
module cg_sleep_dec
   import cg_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
) (
   input  cg_state_t         state,
   input  logic [N_IN-1:0]   slot_we,
   input  logic              cg_en,
   output logic [N_IN-1:0]   sleep_slot,
   output logic              sleep_calc,
   output logic              sleep_out
);

   // Input slots wake only in the cycle they are written.
   assign sleep_slot = cg_en ? ~slot_we : '0;

   // Compute registers run while computing and in the clear cycle.
   assign sleep_calc = cg_en & ~((state == ST_CALC) | (state == ST_CLR));

   // Output register runs while loading beats and while being cleared.
   assign sleep_out  = cg_en & ~((state == ST_OUT) | (state == ST_CLR));

endmodule

// File: rtl/cg_seq_ctrl.sv
// rtl/cg_seq_ctrl.sv - sample/compute/output sequencer with clock-gating sleep control
module cg_seq_ctrl
   import cg_pkg::*;
#(
   parameter int N_IN        = N_IN_DEF,
   parameter int CALC_CYCLES = CALC_CYCLES_DEF,
   parameter int OUT_LEN     = OUT_LEN_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cg_en,
   input  logic                           in_valid,
   input  logic [MODE_W-1:0]              in_mode,
   output logic [N_IN-1:0]                slot_we,
   output logic [MODE_W-1:0]              mode_q,
   output logic                           calc_en,
   output logic [$clog2(CALC_CYCLES):0]   calc_step,
   output logic                           out_en,
   output logic [$clog2(OUT_LEN):0]       out_sel,
   output logic                           out_valid,
   output logic [N_IN-1:0]                sleep_slot,
   output logic                           sleep_calc,
   output logic                           sleep_out,
   output logic                           busy
);

   localparam int CNT_W  = $clog2(N_IN) + 1;
   localparam int STEP_W = $clog2(CALC_CYCLES) + 1;
   localparam int BEAT_W = $clog2(OUT_LEN) + 1;

   cg_state_t           state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [STEP_W-1:0]   step, step_nxt;
   logic [BEAT_W-1:0]   beat, beat_nxt;
   logic [MODE_W-1:0]   mode_nxt;

   // State, counters, latched mode and the delayed output-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         step      <= '0;
         beat      <= '0;
         mode_q    <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         step      <= step_nxt;
         beat      <= beat_nxt;
         mode_q    <= mode_nxt;
         out_valid <= (state == ST_OUT);
      end
   end

   // Next-state and counter update; counters return to 0 when their phase ends.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = step;
      beat_nxt  = beat;
      mode_nxt  = mode_q;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               mode_nxt = in_mode;
               if (N_IN == 1) begin
                  state_nxt = ST_CALC;
                  step_nxt  = '0;
               end else begin
                  state_nxt = ST_LOAD;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               if (cnt == CNT_W'(N_IN - 1)) begin
                  state_nxt = ST_CALC;
                  cnt_nxt   = '0;
                  step_nxt  = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         ST_CALC: begin
            if (step == STEP_W'(CALC_CYCLES - 1)) begin
               state_nxt = ST_OUT;
               step_nxt  = '0;
               beat_nxt  = '0;
            end else begin
               step_nxt = step + STEP_W'(1);
            end
         end
         ST_OUT: begin
            if (beat == BEAT_W'(OUT_LEN - 1)) begin
               state_nxt = ST_CLR;
               beat_nxt  = '0;
            end else begin
               beat_nxt = beat + BEAT_W'(1);
            end
         end
         ST_CLR: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            step_nxt  = '0;
            beat_nxt  = '0;
         end
      endcase
   end

   // One-hot slot write, only while samples are being accepted.
   always_comb begin
      slot_we = '0;
      for (int k = 0; k < N_IN; k++) begin
         slot_we[k] = in_valid & ((state == ST_IDLE) | (state == ST_LOAD)) & (cnt == CNT_W'(k));
      end
   end

   assign calc_en   = (state == ST_CALC);
   assign calc_step = step;
   assign out_en    = (state == ST_OUT);
   assign out_sel   = beat;
   assign busy      = (state != ST_IDLE);

   cg_sleep_dec #(
      .N_IN (N_IN)
   ) u_sleep_dec (
      .state      (state),
      .slot_we    (slot_we),
      .cg_en      (cg_en),
      .sleep_slot (sleep_slot),
      .sleep_calc (sleep_calc),
      .sleep_out  (sleep_out)
   );

endmodule

// File: tb/tb_cg_seq_ctrl.sv
// tb/tb_cg_seq_ctrl.sv - self-checking bench for cg_seq_ctrl
module tb_cg_seq_ctrl;

   localparam int N_IN = 6;
   localparam int CC   = 3;
   localparam int OL   = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cg_en;
   logic       in_valid;
   logic [2:0] in_mode;
   logic [5:0] slot_we;
   logic [2:0] mode_q;
   logic       calc_en;
   logic [2:0] calc_step;
   logic       out_en;
   logic [3:0] out_sel;
   logic       out_valid;
   logic [5:0] sleep_slot;
   logic       sleep_calc;
   logic       sleep_out;
   logic       busy;

   cg_seq_ctrl #(.N_IN(N_IN), .CALC_CYCLES(CC), .OUT_LEN(OL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cg_en      (cg_en),
      .in_valid   (in_valid),
      .in_mode    (in_mode),
      .slot_we    (slot_we),
      .mode_q     (mode_q),
      .calc_en    (calc_en),
      .calc_step  (calc_step),
      .out_en     (out_en),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .sleep_slot (sleep_slot),
      .sleep_calc (sleep_calc),
      .sleep_out  (sleep_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ov_cnt;
   int we_cnt;

   // Reference model: samples taken so far, and cycles elapsed since the last-sample edge.
   int         m_n;
   int         m_t;
   logic [2:0] m_mode;

   typedef struct {
      logic       iv;
      logic [2:0] md;
      logic [5:0] e_we;
      logic       e_busy;
      logic       e_ov;
      logic       e_calc;
      logic [2:0] e_step;
      logic       e_out;
      logic [3:0] e_sel;
      logic [2:0] e_mode;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_check();
      logic [5:0] e_we, e_ss;
      logic       e_calc, e_out, e_clr, e_ov, e_busy, e_sc, e_so;
      logic [2:0] e_step;
      logic [3:0] e_sel;
      e_we   = (m_t == 0 && in_valid) ? 6'(1 << m_n) : 6'd0;
      e_calc = (m_t >= 1) && (m_t <= CC);
      e_out  = (m_t > CC) && (m_t <= CC + OL);
      e_clr  = (m_t == CC + OL + 1);
      e_ov   = (m_t >= CC + 2) && (m_t <= CC + OL + 1);
      e_step = e_calc ? 3'(m_t - 1) : 3'd0;
      e_sel  = e_out ? 4'(m_t - CC - 1) : 4'd0;
      e_busy = (m_n > 0) || (m_t > 0);
      e_ss   = cg_en ? ~e_we : 6'd0;
      e_sc   = cg_en & ~(e_calc | e_clr);
      e_so   = cg_en & ~(e_out | e_clr);
      chk("slot_we", slot_we, e_we);
      chk("mode_q", mode_q, m_mode);
      chk("calc_en", calc_en, e_calc);
      chk("calc_step", calc_step, e_step);
      chk("out_en", out_en, e_out);
      chk("out_sel", out_sel, e_sel);
      chk("out_valid", out_valid, e_ov);
      chk("busy", busy, e_busy);
      chk("sleep_slot", sleep_slot, e_ss);
      chk("sleep_calc", sleep_calc, e_sc);
      chk("sleep_out", sleep_out, e_so);
   endtask

   task automatic model_update();
      if (m_t > 0) begin
         m_t++;
         if (m_t > CC + OL + 1) m_t = 0;
      end else if (in_valid) begin
         if (m_n == 0) m_mode = in_mode;
         m_n++;
         if (m_n == N_IN) begin
            m_n = 0;
            m_t = 1;
         end
      end
   endtask

   task automatic model_reset();
      m_n    = 0;
      m_t    = 0;
      m_mode = 3'd0;
   endtask

   // Entered and left at posedge+1; outputs are sampled at the falling edge.
   task automatic cyc(input logic iv, input logic [2:0] md, input logic cg);
      in_valid = iv;
      in_mode  = md;
      cg_en    = cg;
      #4;
      model_check();
      ov_cnt += int'(out_valid);
      we_cnt += $countones(slot_we);
      model_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 3'd5, 6'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd0};
      tbl[1]  = '{1'b1, 3'd2, 6'h02, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[2]  = '{1'b1, 3'd7, 6'h04, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[3]  = '{1'b1, 3'd0, 6'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[4]  = '{1'b1, 3'd1, 6'h10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[5]  = '{1'b1, 3'd3, 6'h20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[6]  = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[7]  = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 3'd5};
      tbl[8]  = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4'd0, 3'd5};
      tbl[9]  = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 3'd5};
      tbl[10] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd1, 3'd5};
      tbl[11] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd2, 3'd5};
      tbl[12] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd3, 3'd5};
      tbl[13] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd4, 3'd5};
      tbl[14] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd5, 3'd5};
      tbl[15] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};
      tbl[16] = '{1'b0, 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 3'd5};

      ov_cnt   = 0;
      we_cnt   = 0;
      rst_n    = 1'b0;
      cg_en    = 1'b1;
      in_valid = 1'b0;
      in_mode  = 3'd0;
      model_reset();

      // Reset values with gating enabled.
      repeat (2) @(posedge clk);
      #5;
      chk("rst out_valid", out_valid, 0);
      chk("rst mode_q", mode_q, 0);
      chk("rst sleep_slot", sleep_slot, 6'h3f);
      chk("rst sleep_calc", sleep_calc, 1);
      chk("rst sleep_out", sleep_out, 1);
      chk("rst busy", busy, 0);
      chk("rst calc_step", calc_step, 0);
      chk("rst out_sel", out_sel, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Continuous pattern, hand-computed timeline.
      for (int i = 0; i < 17; i++) begin
         in_valid = tbl[i].iv;
         in_mode  = tbl[i].md;
         cg_en    = 1'b1;
         #4;
         model_check();
         chk($sformatf("tbl%0d slot_we", i), slot_we, tbl[i].e_we);
         chk($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d calc_en", i), calc_en, tbl[i].e_calc);
         chk($sformatf("tbl%0d calc_step", i), calc_step, tbl[i].e_step);
         chk($sformatf("tbl%0d out_en", i), out_en, tbl[i].e_out);
         chk($sformatf("tbl%0d out_sel", i), out_sel, tbl[i].e_sel);
         chk($sformatf("tbl%0d mode_q", i), mode_q, tbl[i].e_mode);
         model_update();
         @(posedge clk);
         #1;
      end

      // Gapped sample stream: exactly six writes.
      we_cnt = 0;
      begin
         logic [8:0] gaps;
         gaps = 9'b111011001;
         for (int i = 0; i < 9; i++) cyc(gaps[i], (i == 0) ? 3'd3 : 3'd6, 1'b1);
      end
      repeat (12) cyc(1'b0, 3'd0, 1'b1);
      chk("gap slot writes", we_cnt, 6);

      // in_valid during compute must be ignored.
      ov_cnt = 0;
      for (int i = 0; i < 6; i++) cyc(1'b1, (i == 0) ? 3'd1 : 3'd4, 1'b1);
      repeat (3) cyc(1'b1, 3'd2, 1'b1);
      repeat (10) cyc(1'b0, 3'd0, 1'b1);
      chk("ignored in_valid mode_q", mode_q, 1);
      chk("out_valid count", ov_cnt, 6);

      // Gating disabled for a whole pattern, then toggled mid-load.
      for (int i = 0; i < 6; i++) cyc(1'b1, 3'd5, 1'b0);
      repeat (12) cyc(1'b0, 3'd0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 3'd6, i[0]);
      repeat (12) cyc(1'b0, 3'd0, 1'b1);

      // Asynchronous reset after the fourth sample.
      for (int i = 0; i < 4; i++) cyc(1'b1, 3'd7, 1'b1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst busy", busy, 0);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst mode_q", mode_q, 0);
      chk("midrst sleep_calc", sleep_calc, 1);
      @(posedge clk);
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ov_cnt = 0;
      for (int i = 0; i < 6; i++) cyc(1'b1, 3'd2, 1'b1);
      repeat (12) cyc(1'b0, 3'd0, 1'b1);
      chk("post-reset out_valid count", ov_cnt, 6);
      chk("post-reset mode_q", mode_q, 2);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 6), 3'($urandom), ($urandom_range(0, 7) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cg_seq_ctrl.md
Name: cg_seq_ctrl

Overview:
- Sequencing and clock-gating controller for the lab8 9-bit clock-gated datapath.
- Counts the N_IN input samples of one pattern and latches the 3-bit mode from the first sample.
- Steps the datapath through CALC_CYCLES compute cycles, then drives OUT_LEN output beats.
- Generates per-register-group sleep signals that feed the gated clock cells, so each group is clocked only while it must load or clear.

Parameters:
N_IN, 6, input samples per pattern (slot count)
CALC_CYCLES, 3, compute cycles between last sample and first output beat (>=1)
OUT_LEN, 6, output beats per pattern (>=1)

Ports:
clk  in  1  system clock (ungated)
rst_n  in  1  asynchronous active-low reset
cg_en  in  1  1 = clock gating enabled; 0 = all sleep outputs forced 0
in_valid  in  1  input sample strobe
in_mode  in  3  mode; valid only on the first sample of a pattern
slot_we  out  N_IN  one-hot write enable of input slot k (combinational)
mode_q  out  3  latched mode for the current pattern
calc_en  out  1  compute stage active
calc_step  out  $clog2(CALC_CYCLES)+1  compute step index
out_en  out  1  output register loads the beat selected by out_sel
out_sel  out  $clog2(OUT_LEN)+1  output beat index
out_valid  out  1  registered; aligned with the datapath out_data
sleep_slot  out  N_IN  1 = gate clock of input slot k
sleep_calc  out  1  1 = gate clock of compute registers
sleep_out  out  1  1 = gate clock of output register
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, CALC, OUT, CLR. Sample counter cnt, step counter, and beat counter are all registered.
- Reset (async, rst_n=0): state=IDLE and all counters 0. Outputs: mode_q=0, out_valid=0, calc_en=0, out_en=0, calc_step=0, out_sel=0. sleep_* = cg_en ? 1 : 0.
- IDLE: on in_valid=1, capture in_mode into mode_q and assert slot_we[0]. Go to LOAD with cnt=1.
- LOAD: on in_valid=1, assert slot_we[cnt] and increment cnt.
  - If in_valid=0, hold cnt. Gaps are legal.
  - in_mode is ignored after the first sample.
  - At the edge that captures sample N_IN-1, go to CALC with step=0.
  - Degenerate case N_IN=1: IDLE goes directly to CALC.
- slot_we = in_valid & (state in {IDLE, LOAD}) & onehot(cnt). It is never asserted in CALC, OUT, or CLR.
- CALC: calc_en=1 and calc_step counts 0..CALC_CYCLES-1. After the last step, go to OUT with beat=0.
- OUT: lasts OUT_LEN cycles. out_en=1 and out_sel=beat. out_valid is registered and goes high one cycle after the datapath loads beat 0.
  - out_valid is high for exactly OUT_LEN consecutive cycles.
  - After the last beat, go to CLR.
- CLR: one cycle. out_en=0. The output register is clocked so the datapath clears out_data to 0. out_valid falls on the first CLR→IDLE edge. Then go to IDLE.
- Latency: from the clock edge that captures the last sample to the first cycle with out_valid=1 is CALC_CYCLES+1 cycles.
- in_valid asserted in CALC, OUT, or CLR: ignored. No slot write and no mode change.
- Sleep decode uses registered state plus in_valid only (glitch-safe for latch-based ICG):
  - sleep_slot[k] = cg_en & ~slot_we[k]
  - sleep_calc = cg_en & ~(state==CALC | (state==CLR))
  - sleep_out = cg_en & ~(state==OUT | state==CLR)
- cg_en=0: sleep_* = 0. Sequencing is identical.
- cg_en may toggle at any time. It affects only sleep_* in the same cycle.
- Reset mid-operation: immediate return to reset values. A partial pattern is discarded.

Decomposition:
- Package cg_pkg:
  - state enum
  - default N_IN / CALC_CYCLES / OUT_LEN constants
  - MODE_W=3, DATA_W=9
- One natural sub-module, cg_sleep_dec: pure decode of state/slot_we/cg_en to sleep_*. It is kept separate so the gating logic can be reviewed and equivalence-checked alone.

Test Plan:
1. Reset with cg_en=1 → out_valid=0, mode_q=0, sleep_slot=6'b111111, sleep_calc=1, sleep_out=1.
2. Continuous 6 samples, first in_mode=3'b101 → slot_we walks 000001..100000, mode_q=5.
   - calc_step 0,1,2.
   - out_valid high exactly 6 cycles starting 4 cycles after the last-sample edge.
   - Then a CLR cycle, then busy=0.
3. Samples with in_valid gaps (pattern 1,0,0,1,1,0,1,1,1) → cnt holds during gaps and exactly 6 slot writes occur. Output timing is relative to the last write.
4. in_valid=1 for 3 cycles during CALC/OUT with in_mode=3'b010 → no slot_we, mode_q unchanged, out_valid count still 6.
5. cg_en=0 for a whole pattern → all sleep_*=0 throughout, sequencing identical to scenario 2. Toggling cg_en mid-LOAD changes only sleep_*.
6. rst_n pulsed low after sample 4 → async return to IDLE, out_valid=0. A fresh 6-sample pattern then completes normally.
